list_walk_arbiter: RTL and testbench

Shared linked-list traversal engine with round-robin arbitration between R requesters. Owns the next-pointer table (N entries, pointer 0 = null). A configuration port loads the table. Each accepted head pointer is walked to the end of its list, and every node is emitted on a valid/ready output stream tagged with the requester index. It sits between the list-head request generators and the pointer consumers, replacing per-requester walkers.

---
 rtl/list_walk_arbiter_if.sv | 40 ++++
 rtl/list_walk_arbiter.sv | 127 ++++++++++++
 tb/tb_list_walk_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/list_walk_arbiter_if.sv
// Bundles the ports of the list walk arbiter: the table configuration port,
// the per-requester head-pointer requests and the node output stream.
//
// Handshake rule for every channel (cfg, req[i], out): a transfer happens in
// a cycle where both valid and ready are high at the rising clock edge. The
// arbiter's ready outputs (cfg_rdy, req_rdy) are combinational from its state
// and inputs. out_vld/out_ptr/out_src/out_last stay stable until out_rdy.
interface list_walk_arbiter_if #(
  parameter int N = 16,
  parameter int R = 2
);
  localparam int W  = $clog2(N);
  localparam int RW = $clog2(R);

  logic                  cfg_vld;
  logic [W-1:0]          cfg_ptr;
  logic [W-1:0]          cfg_next;
  logic                  cfg_rdy;
  logic [R-1:0]          req_vld;
  logic [R-1:0][W-1:0]   req_ptr;
  logic [R-1:0]          req_rdy;
  logic [W-1:0]          out_ptr;
  logic [RW-1:0]         out_src;
  logic                  out_last;
  logic                  out_vld;
  logic                  out_rdy;
  logic                  loop_err;

  // Requester / consumer side.
  modport master (
    output cfg_vld, cfg_ptr, cfg_next, req_vld, req_ptr, out_rdy,
    input  cfg_rdy, req_rdy, out_ptr, out_src, out_last, out_vld, loop_err
  );

  // Arbiter side.
  modport slave (
    input  cfg_vld, cfg_ptr, cfg_next, req_vld, req_ptr, out_rdy,
    output cfg_rdy, req_rdy, out_ptr, out_src, out_last, out_vld, loop_err
  );
endinterface

// File: rtl/list_walk_arbiter.sv
// Shared linked-list walker. Owns an N-entry next-pointer table (pointer 0 is
// null), grants one head pointer at a time in round-robin order and streams
// every node of that list, tagged with the owning requester. Walks longer
// than N nodes are cut off at N and flagged on loop_err.
module list_walk_arbiter #(
  parameter int N = 16,
  parameter int R = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  list_walk_arbiter_if.slave     bus,
  output logic                   dbg_walk
);
  localparam int W  = $clog2(N);
  localparam int RW = $clog2(R);
  localparam int CW = W + 1;

  typedef enum logic {IDLE = 1'b0, WALK = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    table_q [N];
  logic [W-1:0]    table_d [N];
  logic [W-1:0]    cur_q, cur_d;
  logic [RW-1:0]   src_q, src_d;
  logic [RW-1:0]   last_g_q, last_g_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            loop_err_q, loop_err_d;

  logic            gnt_found;
  logic [RW-1:0]   gnt_idx;
  logic [RW-1:0]   cand;
  logic [W-1:0]    nxt;
  logic            last_node;

  assign dbg_walk  = (state_q == WALK);
  assign nxt       = table_q[cur_q];
  // A walk ends at a null next pointer or after N nodes, whichever is first.
  assign last_node = (nxt == '0) || (cnt_q == CW'(N));

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = last_g_q;
    for (int i = 0; i < R; i++) begin
      cand = (cand == RW'(R - 1)) ? '0 : cand + 1'b1;
      if (!gnt_found && bus.req_vld[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Next-state, table update and handshake outputs.
  always_comb begin
    state_d      = state_q;
    table_d      = table_q;
    cur_d        = cur_q;
    src_d        = src_q;
    last_g_d     = last_g_q;
    cnt_d        = cnt_q;
    loop_err_d   = 1'b0;
    bus.cfg_rdy  = 1'b0;
    bus.req_rdy  = '0;
    bus.out_vld  = 1'b0;
    bus.out_ptr  = '0;
    bus.out_src  = '0;
    bus.out_last = 1'b0;
    bus.loop_err = loop_err_q;
    case (state_q)
      IDLE: begin
        bus.cfg_rdy = 1'b1;
        if (bus.cfg_vld) begin
          // Configuration wins over requests; no grant this cycle.
          table_d[bus.cfg_ptr] = bus.cfg_next;
        end else if (gnt_found) begin
          bus.req_rdy[gnt_idx] = 1'b1;
          last_g_d = gnt_idx;
          src_d    = gnt_idx;
          // A null head is consumed without emitting anything.
          if (bus.req_ptr[gnt_idx] != '0) begin
            cur_d   = bus.req_ptr[gnt_idx];
            cnt_d   = CW'(1);
            state_d = WALK;
          end
        end
      end
      WALK: begin
        bus.out_vld  = 1'b1;
        bus.out_ptr  = cur_q;
        bus.out_src  = src_q;
        bus.out_last = last_node;
        if (bus.out_rdy) begin
          if (last_node) begin
            state_d    = IDLE;
            loop_err_d = (nxt != '0);
          end else begin
            cur_d = nxt;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and table registers; reset clears the whole table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      src_q      <= '0;
      last_g_q   <= RW'(R - 1);
      cnt_q      <= '0;
      loop_err_q <= 1'b0;
      for (int i = 0; i < N; i++) table_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      src_q      <= src_d;
      last_g_q   <= last_g_d;
      cnt_q      <= cnt_d;
      loop_err_q <= loop_err_d;
      table_q    <= table_d;
    end
  end
endmodule

// File: tb/tb_list_walk_arbiter.sv
// Directed and randomized bench for list_walk_arbiter. Expected node streams
// come from following a bench-side copy of the table; grants come from a
// round-robin pointer kept by the bench.
module tb_list_walk_arbiter;
  localparam int N  = 16;
  localparam int R  = 2;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic rst;
  logic dbg_walk;

  always #5 clk = ~clk;

  list_walk_arbiter_if #(.N(N), .R(R)) bus ();

  list_walk_arbiter #(.N(N), .R(R)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_walk (dbg_walk)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference state.
  logic [W-1:0] tbl_m [N];
  int           last_g_m;
  logic         pend_loop;
  logic         exp_trunc;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample point on the falling edge; loop_err is checked on every sample.
  task automatic look();
    @(negedge clk);
    chk("loop_err", 32'(bus.loop_err), 32'(pend_loop));
    pend_loop = 1'b0;
  endtask

  function automatic int rr_pick(input logic [R-1:0] v);
    for (int i = 1; i <= R; i++) begin
      if (v[(last_g_m + i) % R]) return (last_g_m + i) % R;
    end
    return -1;
  endfunction

  // Expected node sequence: follow the table from head, at most N nodes.
  task automatic build_list(input logic [W-1:0] head);
    logic [W-1:0] p;
    exp_q.delete();
    p = head;
    while (p != '0 && exp_q.size() < N) begin
      exp_q.push_back(p);
      p = tbl_m[p];
    end
    exp_trunc = (p != '0);
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) tbl_m[i] = '0;
    last_g_m  = R - 1;
    pend_loop = 1'b0;
  endtask

  task automatic cfg_write(input logic [W-1:0] p, input logic [W-1:0] n);
    bus.cfg_vld  = 1'b1;
    bus.cfg_ptr  = p;
    bus.cfg_next = n;
    look();
    chk("cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
    chk("cfg_no_grant", 32'(bus.req_rdy), 32'd0);
    tick();
    tbl_m[p]    = n;
    bus.cfg_vld = 1'b0;
  endtask

  task automatic idle_cycle();
    look();
    chk("idle_vld", 32'(bus.out_vld), 32'd0);
    tick();
  endtask

  // Expect a grant to exp_src this cycle, then the whole walk of its head.
  // rdy_mode: 0 = out_rdy always 1, 1 = first 5 cycles from pat, 2 = random.
  task automatic grant_walk(input int exp_src, input logic [R-1:0] vld_after,
                            input int rdy_mode, input logic [31:0] pat);
    logic [W-1:0] head;
    int cyc;
    head = bus.req_ptr[exp_src];
    bus.cfg_vld = 1'b0;
    bus.out_rdy = 1'b0;
    look();
    chk("grant", 32'(bus.req_rdy), 32'd1 << exp_src);
    chk("gap_vld", 32'(bus.out_vld), 32'd0);
    chk("gap_ptr", 32'(bus.out_ptr), 32'd0);
    chk("gap_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
    last_g_m = exp_src;
    tick();
    bus.req_vld = vld_after;
    build_list(head);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      case (rdy_mode)
        0:       bus.out_rdy = 1'b1;
        1:       bus.out_rdy = (cyc < 5) ? pat[cyc] : 1'b1;
        default: bus.out_rdy = 1'($urandom_range(0, 1));
      endcase
      look();
      chk("out_vld", 32'(bus.out_vld), 32'd1);
      chk("out_ptr", 32'(bus.out_ptr), 32'(exp_q[0]));
      chk("out_src", 32'(bus.out_src), 32'(exp_src));
      chk("out_last", 32'(bus.out_last), 32'(exp_q.size() == 1));
      chk("walk_req_rdy", 32'(bus.req_rdy), 32'd0);
      chk("walk_cfg_rdy", 32'(bus.cfg_rdy), 32'd0);
      if (bus.out_rdy) void'(exp_q.pop_front());
      cyc++;
      tick();
    end
    chk("walk_done", 32'(exp_q.size()), 32'd0);
    pend_loop   = exp_trunc;
    bus.out_rdy = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [R-1:0] v;
    int g;
    rst          = 1'b1;
    bus.cfg_vld  = 1'b0;
    bus.cfg_ptr  = '0;
    bus.cfg_next = '0;
    bus.req_vld  = '0;
    bus.req_ptr  = '0;
    bus.out_rdy  = 1'b0;
    reset_model();
    tick();
    tick();
    rst = 1'b0;

    // Reset values.
    look();
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_out_ptr", 32'(bus.out_ptr), 32'd0);
    chk("rst_out_src", 32'(bus.out_src), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
    chk("rst_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
    chk("rst_walk", 32'(dbg_walk), 32'd0);
    tick();

    // Lists: 1->5->3->10, 7->15->8, 2->4, 9->14->11.
    cfg_write(4'd1, 4'd5);  cfg_write(4'd5, 4'd3);
    cfg_write(4'd3, 4'd10); cfg_write(4'd10, 4'd0);
    cfg_write(4'd7, 4'd15); cfg_write(4'd15, 4'd8);
    cfg_write(4'd2, 4'd4);
    cfg_write(4'd9, 4'd14); cfg_write(4'd14, 4'd11);

    // Both requesters hold their heads: strict alternation from requester 0.
    bus.req_ptr[0] = 4'd7;
    bus.req_ptr[1] = 4'd2;
    bus.req_vld    = 2'b11;
    grant_walk(0, 2'b11, 0, 0);
    grant_walk(1, 2'b11, 0, 0);
    grant_walk(0, 2'b11, 0, 0);
    grant_walk(1, 2'b00, 0, 0);

    // Single walk 1,5,3,10 from requester 0.
    bus.req_ptr[0] = 4'd1;
    bus.req_vld    = 2'b01;
    grant_walk(0, 2'b00, 0, 0);

    // Null head from requester 1, then requester 0 wins the tie.
    bus.req_ptr[1] = 4'd0;
    bus.req_vld    = 2'b10;
    grant_walk(1, 2'b00, 0, 0);
    bus.req_ptr[0] = 4'd1;
    bus.req_ptr[1] = 4'd2;
    bus.req_vld    = 2'b11;
    grant_walk(0, 2'b00, 0, 0);

    // Config and request together: write first, grant next cycle sees it.
    bus.cfg_vld    = 1'b1;
    bus.cfg_ptr    = 4'd12;
    bus.cfg_next   = 4'd13;
    bus.req_ptr[0] = 4'd12;
    bus.req_vld    = 2'b01;
    look();
    chk("cfgreq_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
    chk("cfgreq_no_grant", 32'(bus.req_rdy), 32'd0);
    tick();
    tbl_m[12]   = 4'd13;
    bus.cfg_vld = 1'b0;
    grant_walk(0, 2'b00, 0, 0);

    // Backpressure 0,1,0,0,1 on walk 9,14,11.
    bus.req_ptr[0] = 4'd9;
    bus.req_vld    = 2'b01;
    grant_walk(0, 2'b00, 1, 32'b10010);

    // Cycle 1->2->1: truncated at N nodes with a single loop_err pulse.
    cfg_write(4'd1, 4'd2);
    cfg_write(4'd2, 4'd1);
    bus.req_ptr[0] = 4'd1;
    bus.req_vld    = 2'b01;
    grant_walk(0, 2'b00, 0, 0);
    idle_cycle();
    idle_cycle();

    // Repeat the cyclic walk and reset it part-way through.
    bus.req_vld = 2'b01;
    look();
    chk("rst_run_grant", 32'(bus.req_rdy), 32'd1);
    tick();
    bus.req_vld = 2'b00;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("rst_run_vld", 32'(bus.out_vld), 32'd1);
      tick();
    end
    rst = 1'b1;
    look();
    chk("rst_run_hold", 32'(bus.out_vld), 32'd1);
    tick();
    rst = 1'b0;
    bus.out_rdy = 1'b0;
    reset_model();
    look();
    chk("midrst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("midrst_out_ptr", 32'(bus.out_ptr), 32'd0);
    chk("midrst_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
    chk("midrst_walk", 32'(dbg_walk), 32'd0);
    tick();

    // Every entry must now be null: each head is a one-node walk.
    for (int p = 1; p < N; p++) begin
      g = $urandom_range(0, R - 1);
      bus.req_ptr[g] = W'(p);
      bus.req_vld    = R'(1) << g;
      grant_walk(g, 2'b00, 2, 0);
    end

    // Random table writes and competing requests under random backpressure.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_write(W'($urandom_range(1, N - 1)), W'($urandom_range(0, N - 1)));
      end else begin
        v = R'($urandom_range(1, (1 << R) - 1));
        for (int r = 0; r < R; r++) bus.req_ptr[r] = W'($urandom_range(0, N - 1));
        bus.req_vld = v;
        g = rr_pick(v);
        grant_walk(g, 2'b00, 2, 0);
      end
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
